// File: rtl/arrow_lamp_shifter.sv
// arrow_lamp_shifter: serialises the parallel lamp vector into an external
// chain of 595-style shift/latch registers.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   lamps            : parallel lamp vector from the decoder
//   start            : refresh request (queued as pending while busy)
//   auto_en          : refresh automatically when lamps differ from last frame
//   blank            : force the lamp bank dark through oe_n
//   sclk/sdata/latch : shift clock, serial data, storage latch strobe
//   oe_n             : chain output enable, active low (combinational)
//   busy/done        : frame in progress / one-cycle completion pulse
module arrow_lamp_shifter #(
    parameter int unsigned N_LAMPS   = 16,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LAMPS-1:0] lamps,
    input  logic               start,
    input  logic               auto_en,
    input  logic               blank,
    output logic               sclk,
    output logic               sdata,
    output logic               latch,
    output logic               oe_n,
    output logic               busy,
    output logic               done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (N_LAMPS > 1) ? $clog2(N_LAMPS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LAMPS - 1);

    logic [1:0]         state_q, state_d;
    logic [N_LAMPS-1:0] shadow_q, shadow_d;
    logic [N_LAMPS-1:0] last_sent_q, last_sent_d;
    logic               pending_q, pending_d;
    logic               sent_once_q, sent_once_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sclk_q, sclk_d;
    logic               sdata_q, sdata_d;
    logic               latch_q, latch_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               go_c;

    // Map a shift-order index to the lamp bit position.
    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
        return MSB_FIRST ? (IDX_LAST - idx) : idx;
    endfunction

    assign go_c = start | pending_q | (auto_en & (lamps != last_sent_q));

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            last_sent_q <= '0;
            pending_q   <= 1'b0;
            sent_once_q <= 1'b0;
            idx_q       <= '0;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            latch_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            last_sent_q <= last_sent_d;
            pending_q   <= pending_d;
            sent_once_q <= sent_once_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            sdata_q     <= sdata_d;
            latch_q     <= latch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        last_sent_d = last_sent_q;
        pending_d   = pending_q;
        sent_once_d = sent_once_q;
        idx_d       = idx_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        sdata_d     = sdata_q;
        latch_d     = latch_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (go_c) begin
                    state_d     = S_SHIFT;
                    shadow_d    = lamps;
                    last_sent_d = lamps;
                    pending_d   = 1'b0;
                    idx_d       = '0;
                    div_d       = '0;
                    sclk_d      = 1'b0;
                    sdata_d     = lamps[bit_pos('0)];
                    busy_d      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (start) pending_d = 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge ends a bit; new data only appears while sclk is low.
                        sclk_d = 1'b0;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_LATCH;
                            latch_d = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            sdata_d = shadow_q[bit_pos(idx_q + IDX_W'(1))];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_LATCH: begin
                if (start) pending_d = 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    latch_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                if (start) pending_d = 1'b1;
                sent_once_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sclk  = sclk_q;
    assign sdata = sdata_q;
    assign latch = latch_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign oe_n  = blank | ~sent_once_q;

endmodule

// File: tb/tb_arrow_lamp_shifter.sv
// tb_arrow_lamp_shifter: scoreboard bench for arrow_lamp_shifter.
// Instance 0 uses defaults; instance 1 is LSB-first with CLK_DIV=1.
module tb_arrow_lamp_shifter;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] lamps0, lamps1;
    logic start0, start1, auto0, auto1, blank0, blank1;
    logic sclk0, sdata0, latch0, oe_n0, busy0, done0;
    logic sclk1, sdata1, latch1, oe_n1, busy1, done1;

    always #5 clk = ~clk;

    arrow_lamp_shifter dut0 (
        .clk(clk), .rst_n(rst_n), .lamps(lamps0), .start(start0),
        .auto_en(auto0), .blank(blank0), .sclk(sclk0), .sdata(sdata0),
        .latch(latch0), .oe_n(oe_n0), .busy(busy0), .done(done0)
    );

    arrow_lamp_shifter #(.N_LAMPS(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .lamps(lamps1), .start(start1),
        .auto_en(auto1), .blank(blank1), .sclk(sclk1), .sdata(sdata1),
        .latch(latch1), .oe_n(oe_n1), .busy(busy1), .done(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: reconstructs each frame from sclk rising edges and scores it.
    logic [1:0] s_sclk, s_sdata, s_latch, s_busy, s_done;
    assign s_sclk  = {sclk1, sclk0};
    assign s_sdata = {sdata1, sdata0};
    assign s_latch = {latch1, latch0};
    assign s_busy  = {busy1, busy0};
    assign s_done  = {done1, done0};

    int exp_len   [2] = '{133, 34};
    int exp_first [2] = '{5, 2};
    int exp_latch [2] = '{4, 1};

    logic [15:0] word [2] = '{16'h0, 16'h0};
    int nbits     [2] = '{0, 0};
    int latch_cnt [2] = '{0, 0};
    int busy_cnt  [2] = '{0, 0};
    int first_at  [2] = '{0, 0};
    int idle_cnt  [2] = '{0, 0};
    int last_gap  [2] = '{0, 0};
    int frames    [2] = '{0, 0};
    bit data_ok   [2] = '{1'b1, 1'b1};
    bit prev_sclk [2] = '{1'b0, 1'b0};
    bit prev_busy [2] = '{1'b0, 1'b0};
    bit prev_sdata[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                nbits[d]     = 0;
                busy_cnt[d]  = 0;
                latch_cnt[d] = 0;
                prev_busy[d] = 1'b0;
                prev_sclk[d] = 1'b0;
                idle_cnt[d]  = 0;
            end else begin
                if (s_busy[d]) begin
                    if (!prev_busy[d]) begin
                        last_gap[d]  = idle_cnt[d];
                        busy_cnt[d]  = 0;
                        nbits[d]     = 0;
                        latch_cnt[d] = 0;
                        word[d]      = 16'h0;
                        data_ok[d]   = 1'b1;
                    end
                    busy_cnt[d]++;
                    if (s_sclk[d] && !prev_sclk[d]) begin
                        if (nbits[d] == 0) first_at[d] = busy_cnt[d];
                        word[d] = (d == 0) ? {word[d][14:0], s_sdata[d]}
                                           : {s_sdata[d], word[d][15:1]};
                        nbits[d]++;
                    end
                    if (s_sclk[d] && prev_sclk[d] && (s_sdata[d] != prev_sdata[d]))
                        data_ok[d] = 1'b0;
                    if (s_latch[d]) latch_cnt[d]++;
                    if (s_done[d]) begin
                        frames[d]++;
                        chk($sformatf("bits%0d", d), nbits[d], 16);
                        chk($sformatf("latch_len%0d", d), latch_cnt[d], exp_latch[d]);
                        chk($sformatf("first_edge%0d", d), first_at[d], exp_first[d]);
                        chk($sformatf("data_stable%0d", d), data_ok[d], 1);
                        if (d == 0) begin
                            if (q0.size() == 0) chk("unexpected_frame0", 1, 0);
                            else chk("frame_data0", word[d], q0.pop_front());
                        end else begin
                            if (q1.size() == 0) chk("unexpected_frame1", 1, 0);
                            else chk("frame_data1", word[d], q1.pop_front());
                        end
                    end
                end else begin
                    if (prev_busy[d]) begin
                        chk($sformatf("busy_len%0d", d), busy_cnt[d], exp_len[d]);
                        idle_cnt[d] = 1;
                    end else begin
                        idle_cnt[d]++;
                    end
                    if (s_done[d]) chk($sformatf("done_outside_busy%0d", d), 1, 0);
                end
                prev_busy[d]  = s_busy[d];
                prev_sclk[d]  = s_sclk[d];
                prev_sdata[d] = s_sdata[d];
            end
        end
    end

    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_frames(input int d, input int target, input int budget);
        int n;
        n = 0;
        while (frames[d] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames[d] < target) chk($sformatf("timeout_dut%0d", d), frames[d], target);
    endtask

    int f;
    int n;

    initial begin
        rst_n  = 1'b0;
        lamps0 = 16'h0; lamps1 = 16'h0;
        start0 = 1'b0;  start1 = 1'b0;
        auto0  = 1'b0;  auto1  = 1'b0;
        blank0 = 1'b0;  blank1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk0, 0);
        chk("rst_sdata", sdata0, 0);
        chk("rst_latch", latch0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_oe_n", oe_n0, 1);
        chk("rst_oe_n1", oe_n1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frames on both instances.
        lamps1 = 16'h0001; q1.push_back(16'h0001); pulse_start(1);
        lamps0 = 16'hA5C3; q0.push_back(16'hA5C3); pulse_start(0);
        chk("oe_n_before_first", oe_n0, 1);
        wait_frames(0, 1, 400);
        wait_frames(1, 1, 100);
        repeat (2) @(negedge clk);
        chk("oe_n_after_done0", oe_n0, 0);
        chk("oe_n_after_done1", oe_n1, 0);

        // Repeated starts with a mid-frame lamp change collapse into one follow-up.
        lamps0 = 16'h1234; q0.push_back(16'h1234); pulse_start(0);
        repeat (20) @(negedge clk);
        lamps0 = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            pulse_start(0);
            repeat (10) @(negedge clk);
        end
        q0.push_back(16'hFFFF);
        wait_frames(0, 3, 600);
        chk("pending_gap", last_gap[0], 1);
        repeat (50) @(negedge clk);
        chk("no_extra_frame", frames[0], 3);

        // Auto refresh: one frame per change only.
        lamps0 = 16'h0F0F; q0.push_back(16'h0F0F);
        auto0 = 1'b1;
        repeat (500) @(negedge clk);
        chk("auto_one_frame", frames[0], 4);
        lamps0 = 16'h0F0E; q0.push_back(16'h0F0E);
        repeat (300) @(negedge clk);
        chk("auto_change_frame", frames[0], 5);
        auto0 = 1'b0;

        // Blank holds oe_n high without stalling the frame.
        blank0 = 1'b1;
        #1 chk("blank_oe_n", oe_n0, 1);
        lamps0 = 16'h5555; q0.push_back(16'h5555); pulse_start(0);
        repeat (60) @(negedge clk);
        chk("blank_mid_oe_n", oe_n0, 1);
        chk("blank_mid_busy", busy0, 1);
        wait_frames(0, 6, 400);
        repeat (3) @(negedge clk);
        chk("blank_after_oe_n", oe_n0, 1);
        blank0 = 1'b0;
        #1 chk("unblank_oe_n", oe_n0, 0);

        // Asynchronous reset during bit 7 of a frame.
        lamps0 = 16'h3C3C; pulse_start(0);
        n = 0;
        while (!(nbits[0] >= 8 && sclk0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit7", nbits[0], 8);
        f = frames[0];
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sclk", sclk0, 0);
        chk("arst_latch", latch0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_oe_n", oe_n0, 1);
        repeat (3) @(negedge clk);
        chk("arst_no_done", frames[0], f);
        rst_n = 1'b1;
        lamps0 = 16'hA5C3; q0.push_back(16'hA5C3); pulse_start(0);
        wait_frames(0, f + 1, 400);
        repeat (3) @(negedge clk);
        chk("post_reset_oe_n", oe_n0, 0);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
